mux_nx1_reg: RTL

- Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on every channel and on the output.
- Two select modes: explicit select (MS port) and round-robin arbitration among valid channels.
- Sits between CORDIC datapath stages, e.g. choosing between the seed, iteration-feedback and range-reduced operands into the iteration register.
- Provides one output register stage with backpressure.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/mux_nx1_reg_rr_arbiter.sv | 33 +++
 rtl/mux_nx1_reg.sv | 100 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC datapath blocks.
// Holds the operand-mux mode encodings and the select-width helper.
package cordic_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Select fields are never narrower than one bit, even for N=1 style corner cases.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_reg_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping modulo N.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter_n
    import cordic_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = SEL_W'(w_pos);
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_reg.sv
// N-input, W-bit registered operand multiplexer with one output register stage.
// Channel choice is either an explicit select (MS) or round-robin among valid inputs.
module mux_nx1_reg
    import cordic_pkg::*;
#(
    parameter int  W     = 8,
    parameter int  N     = 2,
    parameter int  MODE  = 0,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   MS,
    input  logic [N*W-1:0]     d_in,
    input  logic [N-1:0]       v_in,
    output logic [N-1:0]       rdy_in,
    output logic [W-1:0]       d_out,
    output logic               v_out,
    input  logic               rdy_out,
    output logic [SEL_W-1:0]   ch_out
);

    // Handshake: a beat moves on channel i when v_in[i] && rdy_in[i]; the output beat
    // moves when v_out && rdy_out. v_in never looks at rdy_in, while rdy_in is a
    // combinational function of v_in, MS, rdy_out and the held output valid.

    logic [W-1:0]     r_d_out;
    logic             r_v_out;
    logic [SEL_W-1:0] r_ch_out;

    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_idx;
    logic             w_has_grant;
    logic             w_load_en;
    logic             w_xfer;
    logic [W-1:0]     w_sel_data;

    assign w_load_en  = !r_v_out || rdy_out;
    assign w_xfer     = w_load_en && w_has_grant;
    assign rdy_in     = w_load_en ? w_grant : '0;
    assign w_sel_data = d_in[int'(w_idx)*W +: W];

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;

            rr_arbiter_n #(
                .N     (N),
                .SEL_W (SEL_W)
            ) u_arb (
                .i_req   (v_in),
                .i_ptr   (r_ptr),
                .o_grant (w_grant),
                .o_idx   (w_idx),
                .o_any   (w_has_grant)
            );

            // The pointer only moves on an accepted beat, so stalls and idle cycles keep fairness.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + SEL_W'(1);
                end
            end
        end else begin : g_sel
            logic [SEL_W-1:0] w_cand;

            // Out-of-range selects fall back to channel 0 rather than granting nothing.
            always_comb begin
                w_cand      = (int'(MS) >= N) ? '0 : MS;
                w_idx       = w_cand;
                w_has_grant = v_in[w_cand];
                w_grant     = '0;
                w_grant[w_cand] = v_in[w_cand];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out  <= '0;
            r_v_out  <= 1'b0;
            r_ch_out <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_d_out  <= w_sel_data;
                r_ch_out <= w_idx;
                r_v_out  <= 1'b1;
            end else begin
                r_v_out  <= 1'b0;
            end
        end
    end

    assign d_out  = r_d_out;
    assign v_out  = r_v_out;
    assign ch_out = r_ch_out;

endmodule
